// File: rtl/conv_enc_block_ctrl.sv
// Block sequencer between the data/meta FIFOs and the convolutional encoder.
// Optional stall watchdog is compiled in when STALL_TIMEOUT_EN is defined.
module conv_enc_block_ctrl #(
   parameter int SMALL_BYTES    = 132,
   parameter int LARGE_BYTES    = 768,
   parameter int CNT_W          = 10,
   parameter int DONE_W         = 16,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              blk_ready,
   input  logic              meta_empty,
   input  logic [7:0]        meta_q,
   output logic              meta_rdreq,
   input  logic              data_empty,
   output logic              data_rdreq,
   input  logic              enc_ready,
   input  logic              enc_done,
   output logic              enc_start,
   output logic              enc_size,
   output logic              enc_byte_valid,
   output logic              enc_last,
   output logic              busy,
   output logic [DONE_W-1:0] blocks_done,
   output logic              err_stall
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_META,
      S_START,
      S_STREAM,
      S_DRAIN,
      S_WAIT_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DONE_W-1:0] done_q, done_d;
   logic              size_q, size_d;
   logic              valid_q, last_q;
   logic              rd_ok;
   logic              stall_abort;

   // Reads are paced by encoder back-pressure and never issued into an empty FIFO.
   assign rd_ok = (state_q == S_STREAM) && enc_ready && !data_empty && (rem_q != '0);

`ifdef STALL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;

   always_comb begin
      wd_d        = '0;
      err_d       = err_q;
      stall_abort = 1'b0;
      if ((state_q == S_STREAM) && data_empty && (rem_q != '0)) begin
         wd_d = wd_q + 1'b1;
         if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            err_d       = 1'b1;
            stall_abort = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_stall = err_q;
`else
   logic unused_cfg;

   assign stall_abort = 1'b0;
   assign err_stall   = 1'b0;
   assign unused_cfg  = TIMEOUT_CYCLES[0];
`endif

   logic unused_meta;
   assign unused_meta = ^meta_q[7:1];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      done_d     = done_q;
      size_d     = size_q;
      meta_rdreq = 1'b0;
      enc_start  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (blk_ready && !meta_empty) begin
               meta_rdreq = 1'b1;
               state_d    = S_META;
            end
         end
         S_META: begin
            // meta_q is valid here, one cycle after the non-show-ahead read.
            size_d  = meta_q[0];
            rem_d   = meta_q[0] ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES);
            state_d = S_START;
         end
         S_START: begin
            enc_start = 1'b1;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            if (rd_ok) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
            end else if (stall_abort) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_DRAIN: begin
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (enc_done) begin
               done_d  = done_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         done_q  <= '0;
         size_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         size_q  <= size_d;
         valid_q <= rd_ok;
         last_q  <= rd_ok && (rem_q == CNT_W'(1));
      end
   end

   assign data_rdreq     = rd_ok;
   assign enc_size       = size_q;
   assign enc_byte_valid = valid_q;
   assign enc_last       = valid_q && last_q;
   assign busy           = (state_q != S_IDLE);
   assign blocks_done    = done_q;

endmodule

// File: tb/tb_conv_enc_block_ctrl.sv
// Directed bench for conv_enc_block_ctrl: default-size instance plus a tiny
// instance (2/3-byte blocks, 2-bit done counter, 15-cycle watchdog) for wrap and stall.
`timescale 1ns/1ps
module tb_conv_enc_block_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        blk_ready, meta_empty, data_empty, enc_ready, enc_done;
   logic [7:0]  meta_q;
   logic        meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte_valid, enc_last, busy, err_stall;
   logic [15:0] blocks_done;

   logic        w_blk_ready, w_meta_empty, w_data_empty, w_enc_ready, w_enc_done;
   logic [7:0]  w_meta_q;
   logic        w_meta_rdreq, w_data_rdreq, w_enc_start, w_enc_size, w_enc_byte_valid, w_enc_last;
   logic        w_busy, w_err_stall;
   logic [1:0]  w_blocks_done;

   int tests = 0;
   int fails = 0;

   int drv_rd, drv_meta, drv_start, drv_valid, drv_last, drv_last_idx, drv_first;
   int drv_bad_ready, drv_bad_empty, drv_bad_size;
   logic drv_timeout;

`ifdef STALL_TIMEOUT_EN
   localparam int HOLD    = 19;
   localparam bit ERR_EXP = 1'b1;
   localparam int RD_EXP  = 0;
`else
   localparam int HOLD    = 41;
   localparam bit ERR_EXP = 1'b0;
   localparam int RD_EXP  = 2;
`endif

   conv_enc_block_ctrl u_dut (
      .clk            (clk),
      .reset          (reset),
      .blk_ready      (blk_ready),
      .meta_empty     (meta_empty),
      .meta_q         (meta_q),
      .meta_rdreq     (meta_rdreq),
      .data_empty     (data_empty),
      .data_rdreq     (data_rdreq),
      .enc_ready      (enc_ready),
      .enc_done       (enc_done),
      .enc_start      (enc_start),
      .enc_size       (enc_size),
      .enc_byte_valid (enc_byte_valid),
      .enc_last       (enc_last),
      .busy           (busy),
      .blocks_done    (blocks_done),
      .err_stall      (err_stall)
   );

   conv_enc_block_ctrl #(
      .SMALL_BYTES    (2),
      .LARGE_BYTES    (3),
      .CNT_W          (2),
      .DONE_W         (2),
      .TIMEOUT_CYCLES (15)
   ) u_wrap (
      .clk            (clk),
      .reset          (reset),
      .blk_ready      (w_blk_ready),
      .meta_empty     (w_meta_empty),
      .meta_q         (w_meta_q),
      .meta_rdreq     (w_meta_rdreq),
      .data_empty     (w_data_empty),
      .data_rdreq     (w_data_rdreq),
      .enc_ready      (w_enc_ready),
      .enc_done       (w_enc_done),
      .enc_start      (w_enc_start),
      .enc_size       (w_enc_size),
      .enc_byte_valid (w_enc_byte_valid),
      .enc_last       (w_enc_last),
      .busy           (w_busy),
      .blocks_done    (w_blocks_done),
      .err_stall      (w_err_stall)
   );

   // Runs one block on the main instance. mode 0: ready always; 1: ready 1010...;
   // 2: data FIFO empty for 20 cycles after 10 reads. stop_at>0 returns mid-stream.
   task automatic run_block(input logic [7:0] meta, input int mode, input int stop_at);
      int   stall_left;
      logic started, seen_meta, seen_last;
      drv_rd = 0; drv_meta = 0; drv_start = 0; drv_valid = 0; drv_last = 0;
      drv_last_idx = -1; drv_first = -1;
      drv_bad_ready = 0; drv_bad_empty = 0; drv_bad_size = 0;
      drv_timeout = 1'b1;
      stall_left = 20; started = 1'b0; seen_meta = 1'b0; seen_last = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         blk_ready  = !seen_meta;
         meta_empty = 1'b0;
         meta_q     = meta;
         enc_ready  = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
         data_empty = (mode == 2) && (drv_rd >= 10) && (stall_left > 0);
         if (data_empty) stall_left--;
         enc_done   = seen_last;
         #1;
         if (meta_rdreq) begin drv_meta++; seen_meta = 1'b1; end
         if (enc_start) begin drv_start++; started = 1'b1; end
         if (data_rdreq) begin
            if (drv_rd == 0) drv_first = cyc;
            drv_rd++;
            if (!enc_ready) drv_bad_ready++;
            if (data_empty) drv_bad_empty++;
         end
         if (enc_byte_valid) drv_valid++;
         if (enc_last) begin drv_last++; drv_last_idx = drv_valid; seen_last = 1'b1; end
         if (started && busy && (enc_size !== meta[0])) drv_bad_size++;
         if ((stop_at != 0) && (drv_rd == stop_at)) begin drv_timeout = 1'b0; break; end
         if (started && !busy) begin drv_timeout = 1'b0; break; end
      end
      blk_ready = 1'b0;
      enc_done  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      tests++;
      if ({meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte_valid, enc_last, busy, err_stall} !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got %b, want 00000000",
                  {meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte_valid, enc_last, busy, err_stall});
      end
      tests++;
      if (blocks_done !== 16'h0000 || w_blocks_done !== 2'b00) begin
         fails++;
         $display("FAIL reset_blocks_done: got %h/%h, want 0000/0", blocks_done, w_blocks_done);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || meta_rdreq !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b meta_rdreq=%b, want 0 0", busy, meta_rdreq);
      end
   endtask

   task automatic test_small_block();
      run_block(8'h00, 0, 0);
      tests++;
      if (drv_timeout) begin fails++; $display("FAIL small_timeout: block did not finish in budget"); end
      tests++;
      if (drv_rd != 132) begin fails++; $display("FAIL small_reads: got %0d, want 132", drv_rd); end
      tests++;
      if (drv_meta != 1 || drv_start != 1) begin
         fails++; $display("FAIL small_meta_start: meta=%0d start=%0d, want 1 1", drv_meta, drv_start);
      end
      tests++;
      if (drv_first != 3) begin fails++; $display("FAIL small_latency: first read at %0d, want 3", drv_first); end
      tests++;
      if (drv_last != 1 || drv_last_idx != 132 || drv_valid != 132) begin
         fails++;
         $display("FAIL small_last: last=%0d at valid #%0d of %0d, want 1 at #132 of 132",
                  drv_last, drv_last_idx, drv_valid);
      end
      tests++;
      if (blocks_done !== 16'd1) begin fails++; $display("FAIL small_done: got %0d, want 1", blocks_done); end
   endtask

   task automatic test_large_toggle();
      run_block(8'hFF, 1, 0);
      tests++;
      if (drv_timeout || drv_rd != 768) begin
         fails++; $display("FAIL large_reads: got %0d (timeout=%b), want 768", drv_rd, drv_timeout);
      end
      tests++;
      if (drv_bad_ready != 0) begin fails++; $display("FAIL large_ready_gate: %0d reads with enc_ready=0, want 0", drv_bad_ready); end
      tests++;
      if (drv_bad_size != 0) begin fails++; $display("FAIL large_size: %0d cycles enc_size!=1, want 0", drv_bad_size); end
      tests++;
      if (drv_last != 1 || drv_last_idx != 768) begin
         fails++; $display("FAIL large_last: last=%0d at #%0d, want 1 at #768", drv_last, drv_last_idx);
      end
      tests++;
      if (blocks_done !== 16'd2) begin fails++; $display("FAIL large_done: got %0d, want 2", blocks_done); end
   endtask

   task automatic test_data_stall();
      run_block(8'h00, 2, 0);
      tests++;
      if (drv_timeout || drv_rd != 132) begin
         fails++; $display("FAIL stall_reads: got %0d (timeout=%b), want 132", drv_rd, drv_timeout);
      end
      tests++;
      if (drv_bad_empty != 0) begin fails++; $display("FAIL stall_underflow: %0d reads while empty, want 0", drv_bad_empty); end
      tests++;
      if (err_stall !== 1'b0) begin fails++; $display("FAIL stall_err: got %b, want 0", err_stall); end
      tests++;
      if (blocks_done !== 16'd3) begin fails++; $display("FAIL stall_done: got %0d, want 3", blocks_done); end
   endtask

   task automatic test_back_to_back();
      logic metas [6];
      int   k, last_cyc, gap_exp;
      logic finished;
      metas = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      k = 0; last_cyc = 0; finished = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         w_blk_ready  = (k < 6);
         w_meta_empty = 1'b0;
         w_meta_q     = (k > 0) ? {7'h55, metas[k-1]} : 8'h00;
         w_data_empty = 1'b0;
         w_enc_ready  = 1'b1;
         w_enc_done   = 1'b1;
         #1;
         if (w_meta_rdreq) begin
            k++;
            tests++;
            if (w_blocks_done !== 2'((k - 1) % 4) || w_busy !== 1'b0) begin
               fails++;
               $display("FAIL b2b_done_%0d: blocks_done=%0d busy=%b, want %0d 0",
                        k, w_blocks_done, w_busy, (k - 1) % 4);
            end
            if (k > 1) begin
               gap_exp = metas[k-2] ? 8 : 7;
               tests++;
               if (cyc - last_cyc != gap_exp) begin
                  fails++; $display("FAIL b2b_gap_%0d: got %0d cycles, want %0d", k, cyc - last_cyc, gap_exp);
               end
            end
            last_cyc = cyc;
         end
         if (k == 6 && cyc > last_cyc && !w_busy) begin finished = 1'b1; break; end
      end
      w_blk_ready = 1'b0;
      w_enc_done  = 1'b0;
      tests++;
      if (!finished || w_blocks_done !== 2'd2) begin
         fails++; $display("FAIL b2b_wrap_final: finished=%b blocks_done=%0d, want 1 2", finished, w_blocks_done);
      end
   endtask

   task automatic test_stall_timeout();
      int reads;
      reads = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(negedge clk);
         w_blk_ready  = (cyc == 0);
         w_meta_empty = 1'b0;
         w_meta_q     = 8'h00;
         w_enc_ready  = 1'b1;
         w_data_empty = (cyc < HOLD);
         w_enc_done   = (cyc >= HOLD);
         #1;
         if (w_data_rdreq) begin
            reads++;
            if (w_data_empty) begin fails++; $display("FAIL wd_underflow: read while empty at cycle %0d", cyc); end
         end
         if (cyc == HOLD - 2) begin
            tests++;
            if (w_err_stall !== 1'b0) begin fails++; $display("FAIL wd_early: err_stall=%b at cycle %0d, want 0", w_err_stall, cyc); end
         end
         if (cyc == HOLD - 1) begin
            tests++;
            if (w_err_stall !== ERR_EXP || w_busy !== 1'b1 || reads != 0) begin
               fails++;
               $display("FAIL wd_trip: err=%b busy=%b reads=%0d, want %b 1 0", w_err_stall, w_busy, reads, ERR_EXP);
            end
         end
      end
      w_enc_done = 1'b0;
      tests++;
      if (w_busy !== 1'b0 || w_blocks_done !== 2'd3 || reads != RD_EXP) begin
         fails++;
         $display("FAIL wd_complete: busy=%b blocks_done=%0d reads=%0d, want 0 3 %0d", w_busy, w_blocks_done, reads, RD_EXP);
      end
      tests++;
      if (w_err_stall !== ERR_EXP) begin fails++; $display("FAIL wd_sticky: err=%b, want %b", w_err_stall, ERR_EXP); end
   endtask

   task automatic test_reset_mid();
      run_block(8'h00, 0, 82);
      tests++;
      if (drv_timeout || busy !== 1'b1 || enc_byte_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: timeout=%b busy=%b valid=%b, want 0 1 1", drv_timeout, busy, enc_byte_valid);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte_valid, enc_last, busy, err_stall} !== 8'h00) begin
         fails++;
         $display("FAIL mid_outputs: got %b, want 00000000",
                  {meta_rdreq, data_rdreq, enc_start, enc_size, enc_byte_valid, enc_last, busy, err_stall});
      end
      tests++;
      if (blocks_done !== 16'h0000 || w_err_stall !== 1'b0 || w_blocks_done !== 2'b00) begin
         fails++;
         $display("FAIL mid_clear: blocks_done=%h w_err=%b w_done=%0d, want 0000 0 0", blocks_done, w_err_stall, w_blocks_done);
      end
      @(negedge clk);
      reset = 1'b0;
      data_empty = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || data_rdreq !== 1'b0) begin
         fails++; $display("FAIL mid_idle: busy=%b rdreq=%b, want 0 0", busy, data_rdreq);
      end
   endtask

   initial begin
      reset = 1'b1;
      blk_ready = 1'b0; meta_empty = 1'b1; meta_q = 8'h00;
      data_empty = 1'b1; enc_ready = 1'b0; enc_done = 1'b0;
      w_blk_ready = 1'b0; w_meta_empty = 1'b1; w_meta_q = 8'h00;
      w_data_empty = 1'b1; w_enc_ready = 1'b0; w_enc_done = 1'b0;
      test_reset();
      test_small_block();
      test_large_toggle();
      test_data_stall();
      test_back_to_back();
      test_stall_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
